// File: rtl/pad_test_pkg.sv
// pad_test_pkg: shared types and constants for the pad test core.
//   mode_e         - 3-bit test mode held in the command register
//   PATTERN_W      - width of the pattern generator register
//   PRESC_W        - width of the tick prescaler
//   WALK_SEED /
//   LFSR_SEED      - start values loaded into the pattern on a strobe
//   LFSR_TAP_HI/LO - Fibonacci feedback taps (x^10 + x^7 + 1)
//   mode_seed()    - pattern value loaded when a mode is (re)entered
//   prescale_limit() - terminal count 2^arg - 1 for the prescaler
package pad_test_pkg;

  localparam int PATTERN_W    = 10;
  localparam int PRESC_W      = 15;
  localparam int LFSR_TAP_HI  = 9;
  localparam int LFSR_TAP_LO  = 6;

  localparam logic [PATTERN_W-1:0] WALK_SEED = 10'h001;
  localparam logic [PATTERN_W-1:0] LFSR_SEED = 10'h001;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_LOOP  = 3'd1,
    MODE_COUNT = 3'd2,
    MODE_WALK  = 3'd3,
    MODE_LFSR  = 3'd4,
    MODE_EDGE  = 3'd5,
    MODE_RSVD6 = 3'd6,
    MODE_RSVD7 = 3'd7
  } mode_e;

  function automatic logic [PATTERN_W-1:0] mode_seed(input mode_e mode);
    logic [PATTERN_W-1:0] seed;
    seed = '0;
    case (mode)
      MODE_WALK: seed = WALK_SEED;
      MODE_LFSR: seed = LFSR_SEED;
      default:   seed = '0;
    endcase
    return seed;
  endfunction

  // arg is 0..15, so 2^arg - 1 always fits the 15-bit prescaler.
  function automatic logic [PRESC_W-1:0] prescale_limit(input logic [3:0] arg);
    logic [PRESC_W:0] one_hot;
    one_hot = {{PRESC_W{1'b0}}, 1'b1} << arg;
    return PRESC_W'(one_hot - 1'b1);
  endfunction

endpackage

// File: rtl/pad_sync.sv
// pad_sync: two-flop synchronizer for signals asynchronous to clk.
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input bus
//   q     - synchronized output (two clk edges of latency)
module pad_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pad_test_core.sv
// pad_test_core: pad test pattern generator.
//   clk        - single rising-edge clock
//   rst_n      - asynchronous active-low reset (deassertion synchronized
//                outside this block)
//   input_in   - pad-to-core inputs, asynchronous to clk. After
//                synchronization, a 0->1 on bit 7 is a command strobe that
//                loads mode = bits[6:4] and arg = bits[3:0].
//   output_out - core-to-pad pattern, driven straight from flops
// Modes: IDLE drives 0, LOOP echoes the synchronized inputs, COUNT/WALK/LFSR
// step the pattern on a prescaled tick (every 2^arg cycles), EDGE counts
// rising edges of synchronized input bit 0. Modes 6 and 7 act as IDLE.
// Only NUM_INPUT_PADS = 8 and NUM_OUTPUT_PADS = 10 are supported.
module pad_test_core
  import pad_test_pkg::*;
#(
  parameter int NUM_INPUT_PADS  = 8,
  parameter int NUM_OUTPUT_PADS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_INPUT_PADS-1:0]  input_in,
  output logic [NUM_OUTPUT_PADS-1:0] output_out
);

  logic [NUM_INPUT_PADS-1:0] sync_w;

  pad_sync #(.WIDTH(NUM_INPUT_PADS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (input_in),
    .q     (sync_w)
  );

  logic                       prev7_d, prev7_q;
  logic                       prev0_d, prev0_q;
  mode_e                      cmd_mode_d, cmd_mode_q;
  logic [3:0]                 cmd_arg_d, cmd_arg_q;
  logic [PRESC_W-1:0]         presc_d, presc_q;
  logic [PATTERN_W-1:0]       pattern_d, pattern_q;
  logic [NUM_OUTPUT_PADS-1:0] output_d, output_q;

  logic strobe_w;
  logic tick_w;
  logic edge_w;

  always_comb begin
    strobe_w = sync_w[7] & ~prev7_q;
    edge_w   = sync_w[0] & ~prev0_q;
    tick_w   = (presc_q == prescale_limit(cmd_arg_q));
  end

  // Command register and prescaler. A strobe restarts the prescaler even
  // when the same mode is reloaded, and any tick in that cycle is dropped.
  always_comb begin
    prev7_d    = sync_w[7];
    prev0_d    = sync_w[0];
    cmd_mode_d = cmd_mode_q;
    cmd_arg_d  = cmd_arg_q;
    presc_d    = presc_q + 1'b1;
    if (strobe_w) begin
      cmd_mode_d = mode_e'(sync_w[6:4]);
      cmd_arg_d  = sync_w[3:0];
      presc_d    = '0;
    end else if (tick_w) begin
      presc_d    = '0;
    end
  end

  // Pattern generator. The strobe branch comes first so a coincident tick
  // or EDGE-mode input edge is discarded.
  always_comb begin
    pattern_d = pattern_q;
    if (strobe_w) begin
      pattern_d = mode_seed(mode_e'(sync_w[6:4]));
    end else begin
      case (cmd_mode_q)
        MODE_COUNT: if (tick_w) pattern_d = pattern_q + 1'b1;
        MODE_WALK:  if (tick_w) pattern_d = {pattern_q[PATTERN_W-2:0], pattern_q[PATTERN_W-1]};
        MODE_LFSR:  if (tick_w) pattern_d = {pattern_q[PATTERN_W-2:0],
                                             pattern_q[LFSR_TAP_HI] ^ pattern_q[LFSR_TAP_LO]};
        MODE_EDGE:  if (edge_w) pattern_d = pattern_q + 1'b1;
        default:    pattern_d = '0;
      endcase
    end
  end

  // Output mode decode, registered so no input reaches the pads
  // combinationally.
  always_comb begin
    output_d = '0;
    case (cmd_mode_q)
      MODE_LOOP:  output_d = {2'b00, sync_w};
      MODE_COUNT,
      MODE_WALK,
      MODE_LFSR,
      MODE_EDGE:  output_d = pattern_q;
      default:    output_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev7_q    <= 1'b0;
      prev0_q    <= 1'b0;
      cmd_mode_q <= MODE_IDLE;
      cmd_arg_q  <= '0;
      presc_q    <= '0;
      pattern_q  <= '0;
      output_q   <= '0;
    end else begin
      prev7_q    <= prev7_d;
      prev0_q    <= prev0_d;
      cmd_mode_q <= cmd_mode_d;
      cmd_arg_q  <= cmd_arg_d;
      presc_q    <= presc_d;
      pattern_q  <= pattern_d;
      output_q   <= output_d;
    end
  end

  assign output_out = output_q;

endmodule

// File: tb/tb_pad_test_core.sv
// Bench for pad_test_core. Inputs change on the falling edge; outputs are
// read on the falling edge. A strobe driven at falling edge N0 is loaded at
// the third rising edge and its first output appears after the fourth, so
// the strobe task returns at the falling edge where that value is visible.
module tb_pad_test_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] input_in;
  logic [9:0] output_out;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [7:0] in_val;
    logic [9:0] exp_out;
  } loop_vec_t;

  loop_vec_t loop_tab[6];
  logic [9:0] lfsr_early[9];

  pad_test_core #(
    .NUM_INPUT_PADS  (8),
    .NUM_OUTPUT_PADS (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_in   (input_in),
    .output_out (output_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where the first
  // output of the new mode is visible.
  task automatic strobe(input logic [6:0] cmd, input logic [7:0] rest);
    input_in = {1'b1, cmd};
    @(negedge clk);
    input_in = rest;
    repeat (3) @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp;
    n_vec  = 0;
    n_fail = 0;

    loop_tab[0] = '{8'h5A, 10'h05A};
    loop_tab[1] = '{8'h3C, 10'h03C};
    loop_tab[2] = '{8'h7F, 10'h07F};
    loop_tab[3] = '{8'h01, 10'h001};
    loop_tab[4] = '{8'h40, 10'h040};
    loop_tab[5] = '{8'h00, 10'h000};

    lfsr_early[0] = 10'h001; lfsr_early[1] = 10'h002; lfsr_early[2] = 10'h004;
    lfsr_early[3] = 10'h008; lfsr_early[4] = 10'h010; lfsr_early[5] = 10'h020;
    lfsr_early[6] = 10'h040; lfsr_early[7] = 10'h081; lfsr_early[8] = 10'h102;

    // reset: inputs all high while held
    rst_n    = 1'b0;
    input_in = 8'hFF;
    step(3);
    check("reset_hold", output_out, 10'h000);
    input_in = 8'h00;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2);
      check("reset_idle", output_out, 10'h000);
    end

    // LOOP
    strobe(7'h10, 8'h00);
    check("loop_start", output_out, 10'h000);
    exp = 10'h000;
    for (int i = 0; i < 6; i++) begin
      input_in = loop_tab[i].in_val;
      step(2);
      check("loop_early", output_out, exp);
      step(1);
      check("loop_vec", output_out, loop_tab[i].exp_out);
      exp = loop_tab[i].exp_out;
    end

    // mode 7 behaves as IDLE
    strobe(7'h7F, 8'h00);
    check("mode7_idle", output_out, 10'h000);
    step(3);
    check("mode7_hold", output_out, 10'h000);

    // COUNT, arg 2: advances every 4 cycles, wraps after 4096 cycles
    strobe(7'h22, 8'h00);
    check("count_seed", output_out, 10'h000);
    for (int i = 1; i <= 1024; i++) begin
      step(2);
      exp = 10'(i - 1);
      check("count_mid", output_out, exp);
      step(2);
      exp = 10'(i);
      check("count_step", output_out, exp);
    end

    // WALK, arg 0: rotates every cycle; strobe beats the coincident tick
    strobe(7'h30, 8'h00);
    check("walk_seed", output_out, 10'h001);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      exp = 10'h001 << (i % 10);
      check("walk_step", output_out, exp);
    end

    // strobe bit held high gives a single strobe
    input_in = 8'hB0;
    step(4);
    check("held_seed", output_out, 10'h001);
    step(12);
    check("held_no_restrobe", output_out, 10'h004);
    input_in = 8'h30;
    step(3);
    check("held_release", output_out, 10'h020);

    // same-mode re-strobe reloads the seed
    strobe(7'h30, 8'h00);
    check("walk_restrobe", output_out, 10'h001);

    // LFSR: period 1023, never zero
    strobe(7'h40, 8'h00);
    check("lfsr_seed", output_out, 10'h001);
    for (int i = 1; i <= 1023; i++) begin
      step(1);
      if (i <= 8) check("lfsr_early", output_out, lfsr_early[i]);
      if (i < 1023) begin
        check("lfsr_nonzero", {9'b0, output_out != 10'h000}, 10'h001);
        check("lfsr_no_early_repeat", {9'b0, output_out == 10'h001}, 10'h000);
      end else begin
        check("lfsr_period", output_out, 10'h001);
      end
    end

    // EDGE: count pulses on input bit 0
    strobe(7'h50, 8'h00);
    check("edge_seed", output_out, 10'h000);
    for (int p = 1; p <= 5; p++) begin
      input_in = 8'h01;
      step(1);
      input_in = 8'h00;
      step(3);
      exp = 10'(p);
      check("edge_count", output_out, exp);
    end
    check("edge_five", output_out, 10'h005);
    // re-strobe into EDGE while bit 0 also rises: edge discarded
    strobe(7'h51, 8'h00);
    check("edge_restrobe", output_out, 10'h000);
    step(3);
    check("edge_restrobe_hold", output_out, 10'h000);

    // reset mid-mode (COUNT, arg 0)
    strobe(7'h20, 8'h00);
    step(20);
    check("count_fast", output_out, 10'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", output_out, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check("reset_no_retain", output_out, 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
